// File: rtl/ram_range_copy.sv
// rtl/ram_range_copy.sv - copies a block of RAM words from one base address to another
// One word per cycle: read i+1 is presented while write i uses the returned read data.
module ram_range_copy #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic              done,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] ram_raddr_0,
  input  logic [DATA_W-1:0] ram_rdata_0,
  output logic [ADDR_W-1:0] ram_waddr_0,
  output logic              ram_wen_0,
  output logic [DATA_W-1:0] ram_wdata_0
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt;

  // RAM read data arrives exactly when its write is due, so it passes straight through.
  assign ram_wdata_0 = ram_rdata_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      ram_wen_0   <= 1'b0;
      ram_raddr_0 <= '0;
      ram_waddr_0 <= '0;
      dst_r       <= '0;
      len_r       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          ram_wen_0 <= 1'b0;
          if (start) begin
            dst_r <= dst_base;
            len_r <= length;
            cnt   <= '0;
            ready <= 1'b0;
            done  <= 1'b0;
            if (length != '0) begin
              ram_raddr_0 <= src_base;
              state       <= RUN;
            end else begin
              state <= FLUSH;
            end
          end
        end
        RUN: begin
          // cnt is the index of the read presented this cycle; it becomes next cycle's write.
          ram_wen_0   <= 1'b1;
          ram_waddr_0 <= (cnt == '0) ? dst_r : ram_waddr_0 + ADDR_ONE;
          cnt         <= cnt + LEN_ONE;
          if (cnt == len_r - LEN_ONE) begin
            state <= FLUSH;
          end else begin
            ram_raddr_0 <= ram_raddr_0 + ADDR_ONE;
          end
        end
        FLUSH: begin
          ram_wen_0 <= 1'b0;
          ready     <= 1'b1;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_range_copy.sv
// tb/tb_ram_range_copy.sv - scoreboard bench for ram_range_copy with a sparse RAM model
module tb_ram_range_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        done;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] length;
  logic [31:0] ram_raddr_0;
  logic [31:0] ram_rdata_0;
  logic [31:0] ram_waddr_0;
  logic        ram_wen_0;
  logic [31:0] ram_wdata_0;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int cyc_ctr = 0;
  int first_wen = 0;
  int last_wen = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [63:0] exp_q [$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  ram_range_copy dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .ram_raddr_0(ram_raddr_0), .ram_rdata_0(ram_rdata_0),
    .ram_waddr_0(ram_waddr_0), .ram_wen_0(ram_wen_0), .ram_wdata_0(ram_wdata_0)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'd2654435761 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Synchronous RAM: read data registered, read sampled before the same-edge write.
  always @(posedge clk) begin
    ram_rdata_0 <= mem_rd(ram_raddr_0);
    if (ram_wen_0 === 1'b1) mem[ram_waddr_0] = ram_wdata_0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the next expected write.
  always @(negedge clk) begin
    cyc_ctr++;
    if (ram_wen_0 === 1'b1) begin
      if (wen_cnt == 0) first_wen = cyc_ctr;
      last_wen = cyc_ctr;
      wen_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", ram_waddr_0, ram_wdata_0);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ram_waddr_0, ram_wdata_0} !== exp_e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   ram_waddr_0, ram_wdata_0, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke);
    int cyc;
    logic [31:0] v;
    @(negedge clk);
    chk("ready_idle", {63'd0, ready}, 64'd1);
    src_base = s;
    dst_base = d;
    length   = 16'(n);
    start    = 1'b1;
    wen_cnt  = 0;
    for (int i = 0; i < n; i++) begin
      v = ref_rd(s + 32'(i));
      exp_q.push_back({d + 32'(i), v});
      ref_mem[d + 32'(i)] = v;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_base = $urandom;
    dst_base = $urandom;
    length   = 16'($urandom);
    @(negedge clk);
    chk("ready_busy", {63'd0, ready}, 64'd0);
    chk("done_cleared", {63'd0, done}, 64'd0);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      if (poke && cyc == 2) begin
        start    = 1'b1;
        src_base = $urandom;
        dst_base = $urandom;
        length   = 16'($urandom_range(1, 5));
      end
      if (poke && cyc == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("latency", 64'(cyc), 64'(n + 1));
    chk("done_set", {63'd0, done}, 64'd1);
    chk("wen_count", 64'(wen_cnt), 64'(n));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    if (n > 0) chk("back_to_back", 64'(last_wen - first_wen), 64'(n - 1));
    for (int i = 0; i < n; i++)
      chk("mem_dst", {32'd0, mem_rd(d + 32'(i))}, {32'd0, ref_rd(d + 32'(i))});
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] d;
    int n;
    rst = 1'b1;
    start = 1'b1;
    src_base = 32'd0;
    dst_base = 32'd0;
    length = 16'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_wen", {63'd0, ram_wen_0}, 64'd0);
    chk("rst_raddr", {32'd0, ram_raddr_0}, 64'd0);
    chk("rst_waddr", {32'd0, ram_waddr_0}, 64'd0);
    start = 1'b0;
    rst = 1'b0;

    preload(32'd10, 32'd15);
    run_copy(32'd10, 32'd12, 1, 1'b0);
    chk("single_word", {32'd0, mem_rd(32'd12)}, 64'd15);
    repeat (3) @(negedge clk);
    chk("done_sticky", {63'd0, done}, 64'd1);

    for (int i = 0; i < 8; i++) preload(32'd100 + 32'(i), 32'(i + 1));
    run_copy(32'd100, 32'd200, 8, 1'b0);
    for (int i = 0; i < 8; i++) chk("burst_val", {32'd0, mem_rd(32'd200 + 32'(i))}, 64'(i + 1));
    chk("burst_untouched", {32'd0, mem_rd(32'd208)}, {32'd0, init_val(32'd208)});

    run_copy(32'd500, 32'd600, 0, 1'b0);

    run_copy(32'hFFFF_FFFE, 32'd50, 4, 1'b0);
    chk("wrap_2", {32'd0, mem_rd(32'd52)}, {32'd0, init_val(32'd0)});

    // Abort: reset lands on the third RUN cycle, so only writes 0 and 1 may commit.
    @(negedge clk);
    src_base = 32'd300;
    dst_base = 32'd400;
    length   = 16'd8;
    start    = 1'b1;
    wen_cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({32'd400 + 32'(i), ref_rd(32'd300 + 32'(i))});
      ref_mem[32'd400 + 32'(i)] = ref_rd(32'd300 + 32'(i));
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wen_count", 64'(wen_cnt), 64'd2);
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_wen", {63'd0, ram_wen_0}, 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++)
      chk("abort_mem", {32'd0, mem_rd(32'd400 + 32'(i))}, {32'd0, ref_rd(32'd400 + 32'(i))});
    exp_q.delete();

    run_copy(32'd700, 32'd800, 8, 1'b1);

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 20);
      s = $urandom;
      if ($urandom_range(0, 1) == 1) d = s - 32'($urandom_range(0, 25));
      else d = s + 32'd100 + 32'($urandom_range(0, 1000));
      run_copy(s, d, n, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
